// File: rtl/tt_scan_pkg.sv
// tt_scan_pkg: shared types and constants for the truth-table scanner.
// Holds the FSM state enum, vector/table widths and a popcount helper.
package tt_scan_pkg;
  localparam int VEC_W = 4;
  localparam int TABLE_W = 16;
  localparam logic [VEC_W-1:0] LAST_VEC = 4'd15;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;
  function automatic logic [4:0] popcount16(input logic [TABLE_W-1:0] x);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < TABLE_W; i++) n = n + 5'(x[i]);
    return n;
  endfunction
endpackage

// File: rtl/tt_func_mux.sv
// tt_func_mux: selects one lab-function output from the shared bank.
// Ports: fn_in (NUM_FUNCS function outputs), sel (function index), y (selected output).
module tt_func_mux #(
  parameter int NUM_FUNCS = 8
) (
  input  logic [NUM_FUNCS-1:0] fn_in,
  input  logic [2:0]           sel,
  output logic                 y
);
  assign y = fn_in[sel];
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: sweeps vectors 0..15 through the function bank and builds a 16-bit truth table.
// Ports: clk, reset (async, active-high), start/func_sel (scan request, function latched at start),
// fn_in (function outputs), vec_out ({A,B,C,D}), busy, done (1-cycle pulse), table_out.
// Optional TT_COMPARE_EN: adds expected_in, match, mismatch_cnt (comparison against expected table).
module truth_table_scanner
  import tt_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_FUNCS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           func_sel,
  input  logic [NUM_FUNCS-1:0] fn_in,
  output logic [VEC_W-1:0]     vec_out,
  output logic                 busy,
  output logic                 done,
  output logic [TABLE_W-1:0]   table_out
`ifdef TT_COMPARE_EN
  ,
  input  logic [TABLE_W-1:0]   expected_in,
  output logic                 match,
  output logic [4:0]           mismatch_cnt
`endif
);
  state_t state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] fsel_q, fsel_d;
  logic [TABLE_W-1:0] table_q, table_d;
  logic fn_y;
  logic accept, last_sample;
  tt_func_mux #(.NUM_FUNCS(NUM_FUNCS)) u_mux (.fn_in(fn_in), .sel(fsel_q), .y(fn_y));
  assign accept = (state_q == IDLE) && start;
  assign last_sample = (state_q == SAMPLE) && (vec_q == LAST_VEC);
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    cnt_d = cnt_q;
    fsel_d = fsel_q;
    table_d = table_q;
    case (state_q)
      IDLE: if (start) begin
        fsel_d = func_sel;
        table_d = '0;
        vec_d = '0;
        state_d = APPLY;
      end
      APPLY: begin
        cnt_d = '0;
        state_d = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(SETTLE_CYCLES - 1)) ? SAMPLE : SETTLE;
      end
      SAMPLE: begin
        table_d[vec_q] = fn_y;
        vec_d = (vec_q == LAST_VEC) ? vec_q : vec_q + 4'd1;
        state_d = (vec_q == LAST_VEC) ? DONE : APPLY;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q <= '0;
      cnt_q <= '0;
      fsel_q <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      cnt_q <= cnt_d;
      fsel_q <= fsel_d;
      table_q <= table_d;
    end
  end
  assign vec_out = vec_q;
  assign busy = (state_q != IDLE) && (state_q != DONE);
  assign done = state_q == DONE;
  assign table_out = table_q;
`ifdef TT_COMPARE_EN
  logic [TABLE_W-1:0] exp_q;
  logic match_q;
  logic [4:0] mm_q;
  // Compare against the final table (including the last sample) so the result is valid alongside done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q <= '0;
      match_q <= 1'b0;
      mm_q <= '0;
    end else if (accept) begin
      exp_q <= expected_in;
      match_q <= 1'b0;
      mm_q <= '0;
    end else if (last_sample) begin
      match_q <= table_d == exp_q;
      mm_q <= popcount16(table_d ^ exp_q);
    end
  end
  assign match = match_q;
  assign mismatch_cnt = mm_q;
`else
  logic unused_cmp;
  assign unused_cmp = accept ^ last_sample;
`endif
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: directed, table-driven checks of truth_table_scanner at S=0, 1 and 3.
module tb_truth_table_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] func_sel = '0;
  logic [7:0] fn0, fn1, fn3;
  logic [3:0] vec0, vec1, vec3;
  logic busy0, busy1, busy3, done0, done1, done3;
  logic [15:0] tab0, tab1, tab3;
  int cmp_n = 0;
  int err_n = 0;
  int d0, d1, d3;
  always #5 clk = ~clk;

  function automatic logic [7:0] bank(input logic [3:0] v);
    logic a, b, c, d;
    logic [15:0] f4;
    logic [7:0] y;
    {a, b, c, d} = v;
    f4 = 16'hFDA5;
    y[0] = a & b & c;
    y[1] = ~b;
    y[2] = a ^ b ^ c ^ d;
    y[3] = f4[v];
    y[4] = a | d;
    y[5] = ~b | c;
    y[6] = ~(a & c);
    y[7] = b ^ d;
    return y;
  endfunction
  assign fn0 = bank(vec0);
  assign fn1 = bank(vec1);
  assign fn3 = bank(vec3);

`ifdef TT_COMPARE_EN
  logic [15:0] expected_in = '0;
  logic match0, match1, match3;
  logic [4:0] mm0, mm1, mm3;
`endif

  truth_table_scanner #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .start(start),
    .func_sel(func_sel), .fn_in(fn0), .vec_out(vec0), .busy(busy0), .done(done0), .table_out(tab0)
`ifdef TT_COMPARE_EN
    , .expected_in(expected_in), .match(match0), .mismatch_cnt(mm0)
`endif
  );
  truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .start(start),
    .func_sel(func_sel), .fn_in(fn1), .vec_out(vec1), .busy(busy1), .done(done1), .table_out(tab1)
`ifdef TT_COMPARE_EN
    , .expected_in(expected_in), .match(match1), .mismatch_cnt(mm1)
`endif
  );
  truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .start(start),
    .func_sel(func_sel), .fn_in(fn3), .vec_out(vec3), .busy(busy3), .done(done3), .table_out(tab3)
`ifdef TT_COMPARE_EN
    , .expected_in(expected_in), .match(match3), .mismatch_cnt(mm3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse (or hold) start, then record the done cycle of each instance; edge 0 samples start.
  task automatic scan(input logic [2:0] sel, input logic hold, input logic chk_vec);
    @(negedge clk);
    func_sel = sel;
    start = 1'b1;
    d0 = 0;
    d1 = 0;
    d3 = 0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (hold && c == 5) func_sel = sel ^ 3'b100;
      if (c == 1) chk("busy_c1", 32'(busy1), 32'd1);
      if (chk_vec && c <= 48) chk($sformatf("vec_c%0d", c), 32'(vec1), 32'((c - 1) / 3));
      if (done0 && d0 == 0) d0 = c;
      if (done3 && d3 == 0) d3 = c;
      if (done1 && d1 == 0) begin
        d1 = c;
        chk("busy_at_done", 32'(busy1), 32'd0);
      end
      if (hold ? (d1 != 0) : (d0 != 0 && d1 != 0 && d3 != 0)) break;
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [15:0] tbl;
  } vec_t;
  vec_t tv[8];

  initial begin
    int pulses;
    tv[0] = '{3'd1, 16'h0F0F};
    tv[1] = '{3'd5, 16'hCFCF};
    tv[2] = '{3'd3, 16'hFDA5};
    tv[3] = '{3'd0, 16'hC000};
    tv[4] = '{3'd2, 16'h6996};
    tv[5] = '{3'd4, 16'hFFAA};
    tv[6] = '{3'd6, 16'h33FF};
    tv[7] = '{3'd7, 16'h5A5A};
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_table", 32'(tab1), 32'd0);
    chk("rst_vec", 32'(vec1), 32'd0);
    for (int i = 0; i < 8; i++) begin
      scan(tv[i].sel, 1'b0, i == 0);
      chk($sformatf("done_cyc_s1_f%0d", tv[i].sel), 32'(d1), 32'd49);
      chk($sformatf("done_cyc_s0_f%0d", tv[i].sel), 32'(d0), 32'd33);
      chk($sformatf("done_cyc_s3_f%0d", tv[i].sel), 32'(d3), 32'd81);
      chk($sformatf("table_s1_f%0d", tv[i].sel), 32'(tab1), 32'(tv[i].tbl));
      chk($sformatf("table_s0_f%0d", tv[i].sel), 32'(tab0), 32'(tv[i].tbl));
      chk($sformatf("table_s3_f%0d", tv[i].sel), 32'(tab3), 32'(tv[i].tbl));
      repeat (2) @(negedge clk);
      chk($sformatf("table_hold_f%0d", tv[i].sel), 32'(tab1), 32'(tv[i].tbl));
    end
    // Start held throughout and func_sel changed mid-scan: one scan of the latched function only.
    scan(3'd1, 1'b1, 1'b0);
    chk("hold_done_cyc", 32'(d1), 32'd49);
    chk("hold_table", 32'(tab1), 32'h0F0F);
    pulses = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    chk("hold_no_second_done", 32'(pulses), 32'd0);
    chk("hold_idle_busy", 32'(busy1), 32'd0);
    // Asynchronous reset mid-scan at cycle 20.
    @(negedge clk);
    func_sel = 3'd1;
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy1), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_table", 32'(tab1), 32'd0);
    chk("mid_rst_vec", 32'(vec1), 32'd0);
    chk("mid_rst_done", 32'(done1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    scan(3'd1, 1'b0, 1'b0);
    chk("post_rst_done_cyc", 32'(d1), 32'd49);
    chk("post_rst_table", 32'(tab1), 32'h0F0F);
`ifdef TT_COMPARE_EN
    repeat (2) @(negedge clk);
    expected_in = 16'h0F0F;
    scan(3'd1, 1'b0, 1'b0);
    chk("cmp_match_eq", 32'(match1), 32'd1);
    chk("cmp_cnt_eq", 32'(mm1), 32'd0);
    repeat (2) @(negedge clk);
    expected_in = 16'h0F0E;
    scan(3'd1, 1'b0, 1'b0);
    chk("cmp_match_ne", 32'(match1), 32'd0);
    chk("cmp_cnt_ne", 32'(mm1), 32'd1);
    chk("cmp_cnt_ne_s3", 32'(mm3), 32'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
